// File: rtl/posit_defines_es3.sv
// Shared widths, posit<16,3> constants and helper types for the accumulator-to-posit path.
// The accumulator serialisation is {sgn, scale, fraction, inf, zero}, MSB to LSB.
package posit_defines_es3;

    localparam int FBITS_ACCUM = 24;
    localparam int SCALE_BITS  = 10;
    localparam int POSIT_SERIALIZED_WIDTH_ACCUM_PROD_ES3 = 1 + SCALE_BITS + FBITS_ACCUM + 2;

    localparam logic [15:0] POSIT16_ES3_MAXPOS = 16'h7FFF;
    localparam logic [15:0] POSIT16_ES3_MINPOS = 16'h0001;
    localparam logic [15:0] POSIT16_ES3_NAR    = 16'h8000;
    localparam logic signed [9:0] POSIT16_ES3_SCALE_MAX = 10'sd111;
    localparam logic signed [9:0] POSIT16_ES3_SCALE_MIN = -10'sd120;

    // Zero padding below the fraction so that no regime shift ever drops a bit.
    localparam int REGIME_PAD = 14;
    localparam int ASM_W      = 2 + 3 + FBITS_ACCUM + REGIME_PAD;

    typedef struct packed {
        logic                    sgn;
        logic signed [9:0]       scale;
        logic [FBITS_ACCUM-1:0]  fraction;
        logic                    inf;
        logic                    zero;
    } value_accum_prod;

    typedef struct packed {
        logic        sgn;
        logic        inf;
        logic        zero;
        logic        satmax;
        logic        satmin;
        logic [14:0] mag;
        logic        guard;
        logic        sticky;
    } assembled_t;

    function automatic logic [ASM_W-1:0] shift_right(input logic [ASM_W-1:0] v,
                                                      input logic [4:0] amt,
                                                      input logic fill);
        logic [2*ASM_W-1:0] wide;
        wide = {{ASM_W{fill}}, v} >> amt;
        return wide[ASM_W-1:0];
    endfunction

endpackage

// File: rtl/posit16_es3_round.sv
// Round-to-nearest-even, magnitude clamp, sign and special-value encoding for posit<16,3>.
module posit16_es3_round
    import posit_defines_es3::*;
(
    input  assembled_t  val_i,
    output logic [15:0] posit_o,
    output logic        inexact_o
);

    logic        inc;
    logic [15:0] sum;
    logic [15:0] mag;

    always_comb begin
        inc = val_i.guard & (val_i.sticky | val_i.mag[0]);
        sum = {1'b0, val_i.mag} + {15'd0, inc};
        mag = sum;
        // A finite nonzero value never encodes as zero or NaR.
        if (val_i.satmax || sum[15]) begin
            mag = POSIT16_ES3_MAXPOS;
        end else if (val_i.satmin || (sum == 16'd0)) begin
            mag = POSIT16_ES3_MINPOS;
        end
        posit_o   = val_i.sgn ? (~mag + 16'd1) : mag;
        inexact_o = val_i.guard | val_i.sticky | val_i.satmax | val_i.satmin;
        if (val_i.inf) begin
            posit_o   = POSIT16_ES3_NAR;
            inexact_o = 1'b0;
        end else if (val_i.zero) begin
            posit_o   = 16'h0000;
            inexact_o = 1'b0;
        end
    end

endmodule

// File: rtl/accum_prod_to_posit16_es3.sv
// Three-stage pipeline (decode, assemble, round/encode) converting a raw accumulator value
// to posit<16,3>. valid/ready: a transfer happens on a rising edge where valid & ready are both high.
module accum_prod_to_posit16_es3
    import posit_defines_es3::*;
(
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic [POSIT_SERIALIZED_WIDTH_ACCUM_PROD_ES3-1:0] in_accum,
    input  logic                                             in_truncated,
    input  logic                                             in_valid,
    output logic                                             in_ready,
    output logic [15:0]                                      out_posit,
    output logic                                             out_inexact,
    output logic                                             out_valid,
    input  logic                                             out_ready
);

    logic adv;
    value_accum_prod in_val;

    // Stage 1 registers
    value_accum_prod s1_val_q;
    logic            s1_trunc_q, s1_valid_q, s1_satmax_q, s1_satmin_q;
    logic [6:0]      s1_k_q, s1_k_d;
    logic [2:0]      s1_e_q, s1_e_d;
    logic            s1_satmax_d, s1_satmin_d;

    // Stage 2 registers
    assembled_t      s2_q, s2_d;
    logic            s2_valid_q;

    // Stage 3 registers
    logic [15:0]     s3_posit_q, s3_posit_d;
    logic            s3_inexact_q, s3_inexact_d, s3_valid_q;

    logic            neg_k;
    logic [4:0]      shamt;
    logic [ASM_W-1:0] asm_vec, asm_shifted;

    assign adv      = ~s3_valid_q | out_ready;
    assign in_ready = adv;
    assign in_val   = in_accum;

    always_comb begin
        s1_k_d      = in_val.scale[9:3];  // floor(scale / 8)
        s1_e_d      = in_val.scale[2:0];
        s1_satmax_d = in_val.scale > POSIT16_ES3_SCALE_MAX;
        s1_satmin_d = in_val.scale < POSIT16_ES3_SCALE_MIN;
    end

    // k >= 0 starts from "10" and fills with ones; k < 0 starts from "01" and fills with zeros.
    always_comb begin
        neg_k       = s1_k_q[6];
        shamt       = neg_k ? ~s1_k_q[4:0] : s1_k_q[4:0];
        asm_vec     = {~neg_k, neg_k, s1_e_q, s1_val_q.fraction, {REGIME_PAD{1'b0}}};
        asm_shifted = shift_right(asm_vec, shamt, ~neg_k);
        s2_d.sgn    = s1_val_q.sgn;
        s2_d.inf    = s1_val_q.inf;
        s2_d.zero   = s1_val_q.zero;
        s2_d.satmax = s1_satmax_q;
        s2_d.satmin = s1_satmin_q;
        s2_d.mag    = asm_shifted[ASM_W-1 -: 15];
        s2_d.guard  = asm_shifted[ASM_W-16];
        s2_d.sticky = (|asm_shifted[ASM_W-17:0]) | s1_trunc_q;
    end

    posit16_es3_round u_round (
        .val_i     (s2_q),
        .posit_o   (s3_posit_d),
        .inexact_o (s3_inexact_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_val_q     <= '0;
            s1_trunc_q   <= 1'b0;
            s1_k_q       <= '0;
            s1_e_q       <= '0;
            s1_satmax_q  <= 1'b0;
            s1_satmin_q  <= 1'b0;
            s1_valid_q   <= 1'b0;
            s2_q         <= '0;
            s2_valid_q   <= 1'b0;
            s3_posit_q   <= 16'h0000;
            s3_inexact_q <= 1'b0;
            s3_valid_q   <= 1'b0;
        end else if (adv) begin
            s1_val_q     <= in_val;
            s1_trunc_q   <= in_truncated;
            s1_k_q       <= s1_k_d;
            s1_e_q       <= s1_e_d;
            s1_satmax_q  <= s1_satmax_d;
            s1_satmin_q  <= s1_satmin_d;
            s1_valid_q   <= in_valid;
            s2_q         <= s2_d;
            s2_valid_q   <= s1_valid_q;
            s3_posit_q   <= s3_posit_d;
            s3_inexact_q <= s3_inexact_d;
            s3_valid_q   <= s2_valid_q;
        end
    end

    assign out_posit   = s3_posit_q;
    assign out_inexact = s3_inexact_q;
    assign out_valid   = s3_valid_q;

endmodule

// File: tb/tb_accum_prod_to_posit16_es3.sv
// Bench for accum_prod_to_posit16_es3: directed corner cases, stall/reset scenarios and
// random traffic checked against a bit-list reference model.
module tb_accum_prod_to_posit16_es3;
  import posit_defines_es3::*;

  localparam int W = POSIT_SERIALIZED_WIDTH_ACCUM_PROD_ES3;
  localparam int F = FBITS_ACCUM;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  in_accum;
  logic          in_truncated;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   out_posit;
  logic          out_inexact;
  logic          out_valid;
  logic          out_ready;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic chk_lat = 1'b0;
  int mon_lat;
  logic [16:0] exp_q[$];
  int lat_q[$];

  accum_prod_to_posit16_es3 dut (
    .clk          (clk),
    .rst          (rst),
    .in_accum     (in_accum),
    .in_truncated (in_truncated),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_posit    (out_posit),
    .out_inexact  (out_inexact),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
  );

  // clock / reset-independent cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic sgn, input int scale, input logic [F-1:0] frac,
                                      input logic inf, input logic zero);
    logic [9:0] s;
    s = scale[9:0];
    return {sgn, s, frac, inf, zero};
  endfunction

  // Reference: write out the magnitude as a list of bits, then round on the list.
  function automatic logic [16:0] model(input logic [W-1:0] acc, input logic tr);
    logic sgn, inf, zero, guard, sticky, inexact;
    logic signed [9:0] sc10;
    logic [F-1:0] frac;
    int sc, k, e, top, mag, res;
    bit q[$];
    sgn = acc[W-1];
    sc10 = acc[W-2 -: 10];
    sc = int'(sc10);
    frac = acc[F+1:2];
    inf = acc[1];
    zero = acc[0];
    if (inf) return {1'b0, 16'h8000};
    if (zero) return 17'h0;
    if (sc > 111) begin
      mag = 32767;
      inexact = 1'b1;
    end else if (sc < -120) begin
      mag = 1;
      inexact = 1'b1;
    end else begin
      k = (sc >= 0) ? sc / 8 : -((-sc + 7) / 8);
      e = sc - 8 * k;
      if (k >= 0) begin
        for (int i = 0; i <= k; i++) q.push_back(1'b1);
        q.push_back(1'b0);
      end else begin
        for (int i = 0; i < -k; i++) q.push_back(1'b0);
        q.push_back(1'b1);
      end
      for (int b = 2; b >= 0; b--) q.push_back(e[b]);
      for (int b = F - 1; b >= 0; b--) q.push_back(frac[b]);
      top = 0;
      for (int i = 0; i < 15; i++) top = top * 2 + int'(q[i]);
      guard = q[15];
      sticky = tr;
      for (int i = 16; i < q.size(); i++) sticky = sticky | q[i];
      mag = top + ((guard && (sticky || (top % 2 == 1))) ? 1 : 0);
      if (mag > 32767) mag = 32767;
      if (mag < 1) mag = 1;
      inexact = guard | sticky;
    end
    res = sgn ? 65536 - mag : mag;
    return {inexact, res[15:0]};
  endfunction

  // driver: present one value, wait (bounded) for acceptance, record the expectation
  task automatic drive(input logic [W-1:0] acc, input logic tr, input logic [16:0] exp);
    int waited;
    waited = 0;
    in_accum = acc;
    in_truncated = tr;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    chk("in_ready_accept", 32'(in_ready), 32'd1);
    exp_q.push_back(exp);
    lat_q.push_back(chk_lat ? cyc + 3 : -1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drive_model(input logic [W-1:0] acc, input logic tr);
    drive(acc, tr, model(acc, tr));
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 40) begin
      waited++;
      @(posedge clk);
    end
    #1;
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  function automatic logic [W-1:0] rand_acc();
    logic [31:0] r;
    int sel;
    r = $urandom;
    sel = $urandom_range(0, 15);
    return mk(1'(($urandom_range(0, 1))), $urandom_range(0, 259) - 130, r[F-1:0],
              sel == 0, sel == 1);
  endfunction

  // scoreboard: compare every held or transferred output against the expected queue
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", 32'(out_valid), 32'd0);
      end else begin
        chk("out_posit", 32'(out_posit), 32'(exp_q[0][15:0]));
        chk("out_inexact", 32'(out_inexact), 32'(exp_q[0][16]));
        if (out_ready) begin
          mon_lat = lat_q.pop_front();
          void'(exp_q.pop_front());
          if (mon_lat >= 0) chk("latency", 32'(cyc), 32'(mon_lat));
        end else begin
          chk("in_ready_stall", 32'(in_ready), 32'd0);
        end
      end
    end
  end

  logic [F-1:0] g_bit;

  initial begin
    rst = 1'b1;
    in_accum = '0;
    in_truncated = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    g_bit = '0;
    g_bit[F-11] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_posit", 32'(out_posit), 32'h0);
    chk("reset_out_inexact", 32'(out_inexact), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // directed values, back-to-back, fixed 3-cycle latency
    chk_lat = 1'b1;
    drive(mk(1'b0, 0, '0, 1'b0, 1'b0), 1'b0, {1'b0, 16'h4000});
    drive(mk(1'b1, 0, '0, 1'b0, 1'b0), 1'b0, {1'b0, 16'hC000});
    drive(mk(1'b0, 1, '0, 1'b0, 1'b0), 1'b0, {1'b0, 16'h4400});
    drive(mk(1'b0, -1, '0, 1'b0, 1'b0), 1'b0, {1'b0, 16'h3C00});
    drive(mk(1'b0, 0, g_bit, 1'b0, 1'b0), 1'b0, {1'b1, 16'h4000});
    drive(mk(1'b0, 0, g_bit | 24'd1, 1'b0, 1'b0), 1'b0, {1'b1, 16'h4001});
    drive(mk(1'b0, 0, g_bit, 1'b0, 1'b0), 1'b1, {1'b1, 16'h4001});
    drive(mk(1'b0, 0, g_bit | (g_bit << 1), 1'b0, 1'b0), 1'b0, {1'b1, 16'h4002});
    drive(mk(1'b0, 200, '0, 1'b0, 1'b0), 1'b0, {1'b1, 16'h7FFF});
    drive(mk(1'b0, -200, '0, 1'b0, 1'b0), 1'b0, {1'b1, 16'h0001});
    drive(mk(1'b1, 200, '0, 1'b0, 1'b0), 1'b0, {1'b1, 16'h8001});
    drive(mk(1'b1, 200, '1, 1'b1, 1'b1), 1'b1, {1'b0, 16'h8000});
    drive(mk(1'b1, 5, 24'h5A5A5A, 1'b0, 1'b1), 1'b1, {1'b0, 16'h0000});
    drive(mk(1'b0, 111, '0, 1'b0, 1'b0), 1'b0, {1'b1, 16'h7FFF});
    drive(mk(1'b0, -120, '0, 1'b0, 1'b0), 1'b0, {1'b1, 16'h0001});
    drive_model(mk(1'b0, 112, 24'h123456, 1'b0, 1'b0), 1'b0);
    drive_model(mk(1'b1, -121, 24'h654321, 1'b0, 1'b0), 1'b0);
    drive_model(mk(1'b1, 37, 24'hABCDEF, 1'b0, 1'b0), 1'b0);
    drain();

    // six back-to-back inputs with a five-cycle output stall in the middle
    chk_lat = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) drive_model(rand_acc(), 1'($urandom_range(0, 1)));
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // random traffic with random backpressure
    fork
      begin
        for (int i = 0; i < 60; i++) drive_model(rand_acc(), $urandom_range(0, 3) == 0);
      end
      begin
        for (int i = 0; i < 80; i++) begin
          @(posedge clk);
          #1;
          out_ready = $urandom_range(0, 3) != 0;
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain();

    // reset with three values in flight
    chk_lat = 1'b1;
    drive_model(rand_acc(), 1'b0);
    drive_model(rand_acc(), 1'b0);
    drive_model(rand_acc(), 1'b0);
    rst = 1'b1;
    #1;
    chk("midreset_out_valid", 32'(out_valid), 32'd0);
    chk("midreset_out_posit", 32'(out_posit), 32'h0);
    exp_q.delete();
    lat_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("post_reset_in_ready", 32'(in_ready), 32'd1);
    repeat (8) @(posedge clk);
    #1;
    chk("post_reset_no_output", 32'(out_valid), 32'd0);
    drive(mk(1'b0, 1, '0, 1'b0, 1'b0), 1'b0, {1'b0, 16'h4400});
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
